// File: rtl/window_gen_pkg.sv
// Shared types and helpers for the sliding-window generator: FSM encoding,
// window geometry helpers and the per-frame expected window count.
package window_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Offset from the bottom-right pixel of a window to its center.
    function automatic int half_of(input int ksize);
        return (ksize - 1) / 2;
    endfunction

    function automatic int win_width(input int ksize, input int pix_w);
        return ksize * ksize * pix_w;
    endfunction

    function automatic int expected_windows(input int img_w, input int img_h, input int ksize);
        return (img_w - ksize + 1) * (img_h - ksize + 1);
    endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// One image row of delay, addressed by input column. Read is combinational so
// the previous row's pixel is available on the same cycle the new pixel is accepted.
module window_gen_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] col,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rd_data = mem[col];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[col] <= wr_data;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Streaming KSIZE x KSIZE sliding-window generator with valid/ready flow control.
// Optional macro WINDOW_GEN_WIN_CNT_EN adds an accepted-window counter and error flag.
module window_gen
    import window_gen_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int KSIZE = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 10,
    localparam int WIN_W = win_width(KSIZE, PIX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic [WIN_W-1:0] win_o,
    output logic             win_valid_o,
    input  logic             core_ready_i,
    output logic [CNT_W-1:0] cnt_col_o,
    output logic [CNT_W-1:0] cnt_row_o,
    output logic             seg_up_o,
    output logic             done_o
`ifdef WINDOW_GEN_WIN_CNT_EN
    ,
    output logic [19:0]      win_cnt_o,
    output logic             err_o
`endif
);

    localparam int NLB = KSIZE - 1;
    localparam logic [CNT_W-1:0] HALF_C     = CNT_W'(half_of(KSIZE));
    localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] FIRST_EMIT = CNT_W'(KSIZE - 1);
    localparam logic [CNT_W-1:0] SEG_COL    = CNT_W'(IMG_W - 1 - half_of(KSIZE));

    state_t           state_reg;
    logic [CNT_W-1:0] col_reg;
    logic [CNT_W-1:0] row_reg;
    logic [PIX_W-1:0] win_reg [KSIZE][KSIZE];
    logic [PIX_W-1:0] lb_rd   [NLB];
    logic [PIX_W-1:0] col_vec [KSIZE];
    logic             transfer;
    logic             accept;
    logic             emit;
    logic             last_col;
    logic             last_pix;

    assign pix_ready_o = (state_reg == RUN) && (!win_valid_o || core_ready_i);
    assign transfer    = pix_valid_i && pix_ready_o;
    assign accept      = win_valid_o && core_ready_i;
    assign last_col    = (col_reg == LAST_COL);
    assign last_pix    = last_col && (row_reg == LAST_ROW);
    // Only fully populated windows leave the block; early columns just prime the shift register.
    assign emit        = transfer && (row_reg >= FIRST_EMIT) && (col_reg >= FIRST_EMIT);

    genvar gi, gj;
    generate
        for (gi = 0; gi < NLB; gi++) begin : g_lb
            logic [PIX_W-1:0] lb_wr;
            if (gi == 0) begin : g_head
                assign lb_wr = pix_i;
            end else begin : g_chain
                assign lb_wr = lb_rd[gi-1];
            end
            window_gen_line_buffer #(
                .DEPTH (IMG_W),
                .PIX_W (PIX_W),
                .ADDR_W(CNT_W)
            ) u_lb (
                .clk    (clk),
                .wr_en  (transfer),
                .col    (col_reg),
                .wr_data(lb_wr),
                .rd_data(lb_rd[gi])
            );
            // Oldest row sits at the top of the column vector.
            assign col_vec[gi] = lb_rd[NLB-1-gi];
        end
        assign col_vec[KSIZE-1] = pix_i;

        for (gi = 0; gi < KSIZE; gi++) begin : g_row
            for (gj = 0; gj < KSIZE; gj++) begin : g_col
                assign win_o[(gi*KSIZE+gj)*PIX_W +: PIX_W] = win_reg[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win_reg[i][j] <= '0;
                end
            end
        end else if (transfer) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    win_reg[i][j] <= win_reg[i][j+1];
                end
                win_reg[i][KSIZE-1] <= col_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            win_valid_o <= 1'b0;
            cnt_col_o   <= '0;
            cnt_row_o   <= '0;
            seg_up_o    <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            seg_up_o <= accept && (cnt_col_o == SEG_COL);
            done_o   <= 1'b0;

            if (emit) begin
                win_valid_o <= 1'b1;
                cnt_row_o   <= row_reg - HALF_C;
                cnt_col_o   <= col_reg - HALF_C;
            end else if (accept) begin
                win_valid_o <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        col_reg   <= '0;
                        row_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        col_reg <= last_col ? '0 : col_reg + 1'b1;
                        if (last_col) begin
                            row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
                        end
                        if (last_pix) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!win_valid_o || core_ready_i) begin
                        state_reg <= DONE;
                        done_o    <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef WINDOW_GEN_WIN_CNT_EN
    localparam logic [19:0] EXP_WINS = 20'(expected_windows(IMG_W, IMG_H, KSIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_o <= '0;
            err_o     <= 1'b0;
        end else if (state_reg == IDLE && start_i) begin
            win_cnt_o <= '0;
            err_o     <= 1'b0;
        end else begin
            if (accept) begin
                win_cnt_o <= win_cnt_o + 20'd1;
            end
            if (state_reg == DONE && win_cnt_o != EXP_WINS) begin
                err_o <= 1'b1;
            end
        end
    end
`endif

endmodule
